uart_rx_param: RTL

Parametrised oversampling UART receiver; successor to the fixed 8N1 receiver. Adds configurable data width, optional parity, 1 or 2 stop bits, configurable oversample ratio, input synchroniser, false-start rejection, and a ready/valid output with parity/framing/overrun reporting. Sits between the shared baud-tick generator (supplies `i_clk_rx`) and the RX FIFO/command parser.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sampler.sv | 58 +++++
 rtl/uart_rx_param.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg : shared UART receiver/transmitter types and helpers   (rev 1.0)
// ----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_rx_state_t;

  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

  function automatic logic UART_MAJ3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_sampler : line synchroniser, tick counter, 3-sample majority (rev 1.0)
// ----------------------------------------------------------------------------
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic clear,
  input  logic rxd,
  output logic rxd_s,
  output logic bit_val,
  output logic bit_done,
  output logic boundary
);

  localparam int CW  = $clog2(OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          samp_a;
  logic          samp_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      cnt    <= '0;
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
      if (clear)
        cnt <= '0;
      else if (tick)
        cnt <= (cnt == CW'(OVERSAMPLE - 1)) ? '0 : cnt + 1'b1;
      if (tick && cnt == CW'(MID - 1))
        samp_a <= sync2;
      if (tick && cnt == CW'(MID))
        samp_b <= sync2;
    end
  end

  // Third vote is the live sample on the deciding tick.
  assign rxd_s    = sync2;
  assign bit_done = tick && (cnt == CW'(MID + 1));
  assign boundary = tick && (cnt == CW'(OVERSAMPLE - 1));
  assign bit_val  = UART_MAJ3(samp_a, samp_b, sync2);

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_param : parametrised oversampling UART receiver, ready/valid out (rev 1.0)
// ----------------------------------------------------------------------------
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clk_rx,
  input  logic                 i_rxd,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int   BW        = $clog2(DATA_BITS + 1);
  localparam logic PAR_SENSE = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

  uart_rx_state_t       state;
  logic                 rxd_s;
  logic                 bit_val;
  logic                 bit_done;
  logic                 boundary;
  logic                 clear;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bitcnt;
  logic                 stopcnt;
  logic                 par_acc;
  logic                 frm_acc;
  logic                 last_stop;
  logic                 complete;
  logic                 frame_bad;
  logic                 load;

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_sampler (
    .clk      (clk),
    .reset    (reset),
    .tick     (i_clk_rx),
    .clear    (clear),
    .rxd      (i_rxd),
    .rxd_s    (rxd_s),
    .bit_val  (bit_val),
    .bit_done (bit_done),
    .boundary (boundary)
  );

  // Counter idles at 0; the start-detect tick itself is tick 0 of the frame.
  assign clear     = (state == ST_WAIT_HIGH) || ((state == ST_IDLE) && !(i_clk_rx && !rxd_s));
  assign last_stop = (STOP_BITS == 1) || stopcnt;
  assign complete  = (state == ST_STOP) && bit_done && last_stop;
  assign frame_bad = frm_acc | ~bit_val;
  assign load      = complete && (!o_rx_valid || i_rx_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_WAIT_HIGH;
      shreg        <= '0;
      bitcnt       <= '0;
      stopcnt      <= 1'b0;
      par_acc      <= 1'b0;
      frm_acc      <= 1'b0;
      o_rx_data    <= '0;
      o_rx_valid   <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (complete) begin
        if (load) begin
          o_rx_data    <= shreg;
          o_parity_err <= par_acc;
          o_frame_err  <= frame_bad;
          o_rx_valid   <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_rx_valid && i_rx_ready) begin
        o_rx_valid <= 1'b0;
      end

      case (state)
        ST_WAIT_HIGH: begin
          if (rxd_s) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (i_clk_rx && !rxd_s) begin
            state   <= ST_START;
            o_busy  <= 1'b1;
            bitcnt  <= '0;
            stopcnt <= 1'b0;
            par_acc <= 1'b0;
            frm_acc <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_done && bit_val) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else if (boundary) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            shreg  <= {bit_val, shreg[DATA_BITS-1:1]};
            bitcnt <= bitcnt + 1'b1;
          end
          if (boundary && bitcnt == BW'(DATA_BITS))
            state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          if (bit_done)
            par_acc <= bit_val ^ (^shreg) ^ PAR_SENSE;
          if (boundary)
            state <= ST_STOP;
        end
        ST_STOP: begin
          // Frame closes on the last stop bit's decision, not at its end.
          if (bit_done) begin
            frm_acc <= frame_bad;
            if (last_stop) begin
              state  <= bit_val ? ST_IDLE : ST_WAIT_HIGH;
              o_busy <= !bit_val;
            end else begin
              stopcnt <= 1'b1;
            end
          end
        end
        default: begin
          state  <= ST_WAIT_HIGH;
          o_busy <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
